regfile_wb_scheduler: RTL and testbench

//   Schedules the single register-file write port between two writeback sources:
//   the ALU pipe and the load unit. Each source uses a valid/ready handshake.

---
 rtl/regfile_wb_scheduler.sv | 123 ++++++++++++
 tb/tb_regfile_wb_scheduler.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_scheduler.sv
// Register-file writeback scheduler.
// Two writeback sources (ALU pipe and load unit) share the single register-file
// write port. The port is registered, so a write appears one cycle after its
// handshake. A per-register pending-write scoreboard flags RAW hazards to decode
// and stalls issue when a register's counter is saturated.
module regfile_wb_scheduler #(
  parameter int unsigned NUM_REGS  = 32,
  parameter int unsigned ADDR_W    = 5,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned CNT_W     = 2,
  parameter bit          RR_ENABLE = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              iss_valid,
  input  logic [ADDR_W-1:0] iss_rd,
  output logic              iss_ready,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  output logic              hazard,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              ld_valid,
  input  logic [ADDR_W-1:0] ld_rd,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data
);

  typedef enum logic {GRANT_ALU, GRANT_LD} grant_e;

  grant_e              last_grant;
  logic [CNT_W-1:0]    cnt [NUM_REGS];
  logic                inc_en;
  logic                dec_en;
  logic [NUM_REGS-1:0] inc_vec;
  logic [NUM_REGS-1:0] dec_vec;

  // Arbitration: at most one ready per cycle; on conflict either round-robin or ALU first.
  always_comb begin
    alu_ready = 1'b0;
    ld_ready  = 1'b0;
    if (!reset) begin
      if (alu_valid && ld_valid) begin
        if (RR_ENABLE && (last_grant == GRANT_ALU)) ld_ready  = 1'b1;
        else                                        alu_ready = 1'b1;
      end else begin
        alu_ready = alu_valid;
        ld_ready  = ld_valid;
      end
    end
  end

  // Remember which source won most recently; reset favours the ALU on the first conflict.
  always_ff @(posedge clk) begin
    if (reset)                       last_grant <= GRANT_LD;
    else if (alu_valid && alu_ready) last_grant <= GRANT_ALU;
    else if (ld_valid && ld_ready)   last_grant <= GRANT_LD;
  end

  // Registered write port; x0 requests are consumed without a write and leave addr/data untouched.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= 1'b0;
      if (alu_valid && alu_ready && (alu_rd != '0)) begin
        wr_en   <= 1'b1;
        wr_addr <= alu_rd;
        wr_data <= alu_data;
      end else if (ld_valid && ld_ready && (ld_rd != '0)) begin
        wr_en   <= 1'b1;
        wr_addr <= ld_rd;
        wr_data <= ld_data;
      end
    end
  end

  // Issue stall and hazard detection from the current (pre-update) counters.
  always_comb begin
    iss_ready = !reset && ((iss_rd == '0) || (cnt[iss_rd] != '1));
    hazard    = ((rs1_addr != '0) && (cnt[rs1_addr] != '0)) ||
                ((rs2_addr != '0) && (cnt[rs2_addr] != '0));
  end

  // Decode per-register increment/decrement strobes.
  always_comb begin
    inc_en  = iss_valid && iss_ready && (iss_rd != '0);
    dec_en  = wr_en && (wr_addr != '0);
    inc_vec = '0;
    dec_vec = '0;
    if (inc_en) inc_vec[iss_rd]  = 1'b1;
    if (dec_en) dec_vec[wr_addr] = 1'b1;
  end

  // Pending-write counters; decrement coincides with the register-file commit edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned r = 0; r < NUM_REGS; r++) cnt[r] <= '0;
    end else begin
      cnt[0] <= '0;
      for (int unsigned r = 1; r < NUM_REGS; r++) begin
        if (inc_vec[r] && !dec_vec[r])
          cnt[r] <= cnt[r] + CNT_W'(1);
        else if (dec_vec[r] && !inc_vec[r] && (cnt[r] != '0))
          cnt[r] <= cnt[r] - CNT_W'(1);
      end
    end
  end

`ifndef SYNTHESIS
  // A writeback to a register with no outstanding issue is a protocol error.
  a_no_underflow: assert property (@(posedge clk) disable iff (reset)
    dec_en |-> (cnt[wr_addr] != '0));
`endif

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Randomized bench for regfile_wb_scheduler with a queue-based scoreboard.
module tb_regfile_wb_scheduler;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam int NREG   = 32;
  localparam int MAXC   = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic              iss_valid;
  logic [ADDR_W-1:0] iss_rd;
  logic              iss_ready;
  logic [ADDR_W-1:0] rs1_addr, rs2_addr;
  logic              hazard;
  logic              alu_valid;
  logic [ADDR_W-1:0] alu_rd;
  logic [DATA_W-1:0] alu_data;
  logic              alu_ready;
  logic              ld_valid;
  logic [ADDR_W-1:0] ld_rd;
  logic [DATA_W-1:0] ld_data;
  logic              ld_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  regfile_wb_scheduler #(
    .NUM_REGS(NREG), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(2), .RR_ENABLE(1'b1)
  ) dut (
    .clk(clk), .reset(reset),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .hazard(hazard),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data), .ld_ready(ld_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
    int                due;
  } wb_t;

  wb_t exp_q[$];
  wb_t head;
  int  checks   = 0;
  int  failures = 0;
  int  cyc      = 0;

  // Reference model state
  int                pend[NREG];
  logic [ADDR_W-1:0] owed[$];
  bit                last_alu;
  bit                alu_busy, ld_busy;
  int                wr_now, wr_next;
  bit                e_alu, e_ld, e_iss, e_haz;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  // Monitor: every write-port cycle is matched against the scoreboard queue.
  always @(negedge clk) begin
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      head = exp_q.pop_front();
      checks++;
      if (wr_en !== 1'b1 || wr_addr !== head.rd || wr_data !== head.data) begin
        failures++;
        $display("FAIL writeback actual en=%b addr=%0d data=%h required en=1 addr=%0d data=%h cycle=%0d",
                 wr_en, wr_addr, wr_data, head.rd, head.data, cyc);
      end
    end else if (wr_en === 1'b1) begin
      checks++;
      failures++;
      $display("FAIL unexpected_write actual addr=%0d data=%h required wr_en=0 cycle=%0d",
               wr_addr, wr_data, cyc);
    end
  end

  function automatic logic [ADDR_W-1:0] pick_rd();
    int idx;
    logic [ADDR_W-1:0] r;
    if (owed.size() > 0 && $urandom_range(0, 4) != 0) begin
      idx = $urandom_range(0, owed.size() - 1);
      r = owed[idx];
      owed.delete(idx);
      return r;
    end
    return '0;
  endfunction

  task automatic apply_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      reset     = 1'b1;
      alu_valid = 1'b1;
      ld_valid  = 1'b1;
      iss_valid = 1'b1;
      iss_rd    = ADDR_W'($urandom_range(1, 7));
      rs1_addr  = ADDR_W'($urandom_range(1, 7));
      rs2_addr  = ADDR_W'($urandom_range(1, 7));
      #1;
      check("alu_ready_in_reset", {31'b0, alu_ready}, 0);
      check("ld_ready_in_reset", {31'b0, ld_ready}, 0);
      check("iss_ready_in_reset", {31'b0, iss_ready}, 0);
      if (i > 0) begin
        check("wr_en_after_reset", {31'b0, wr_en}, 0);
        check("wr_addr_after_reset", {27'b0, wr_addr}, 0);
        check("wr_data_after_reset", wr_data, 0);
        check("hazard_after_reset", {31'b0, hazard}, 0);
      end
      exp_q.delete();
    end
    for (int r = 0; r < NREG; r++) pend[r] = 0;
    owed.delete();
    alu_busy = 1'b0;
    ld_busy  = 1'b0;
    last_alu = 1'b0;
    wr_now   = 0;
  endtask

  initial begin
    reset = 1'b1; iss_valid = 1'b0; iss_rd = '0; rs1_addr = '0; rs2_addr = '0;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    ld_valid = 1'b0; ld_rd = '0; ld_data = '0;
    apply_reset(2);

    for (int it = 0; it < 600; it++) begin
      if (it == 200 || it == 400) apply_reset(2);
      @(negedge clk);
      reset = 1'b0;
      if (!alu_busy && $urandom_range(0, 3) != 0) begin
        alu_busy = 1'b1;
        alu_rd   = pick_rd();
        alu_data = $urandom;
      end
      if (!ld_busy && $urandom_range(0, 3) != 0) begin
        ld_busy = 1'b1;
        ld_rd   = pick_rd();
        ld_data = $urandom;
      end
      alu_valid = alu_busy;
      ld_valid  = ld_busy;
      iss_valid = ($urandom_range(0, 2) != 0);
      iss_rd    = ADDR_W'($urandom_range(0, 7));
      rs1_addr  = ADDR_W'($urandom_range(0, 7));
      rs2_addr  = ADDR_W'($urandom_range(0, 7));
      #1;

      // Expected behaviour of this cycle
      e_alu = alu_busy && (!ld_busy || !last_alu);
      e_ld  = ld_busy && !e_alu;
      e_iss = (iss_rd == 0) || (pend[iss_rd] < MAXC);
      e_haz = (rs1_addr != 0 && pend[rs1_addr] > 0) || (rs2_addr != 0 && pend[rs2_addr] > 0);
      check("alu_ready", {31'b0, alu_ready}, {31'b0, e_alu});
      check("ld_ready", {31'b0, ld_ready}, {31'b0, e_ld});
      check("iss_ready", {31'b0, iss_ready}, {31'b0, e_iss});
      check("hazard", {31'b0, hazard}, {31'b0, e_haz});

      // Advance the model to the state after the coming edge
      wr_next = 0;
      if (e_alu) begin
        last_alu = 1'b1;
        alu_busy = 1'b0;
        if (alu_rd != 0) exp_q.push_back('{alu_rd, alu_data, cyc + 1});
        wr_next = int'(alu_rd);
      end else if (e_ld) begin
        last_alu = 1'b0;
        ld_busy  = 1'b0;
        if (ld_rd != 0) exp_q.push_back('{ld_rd, ld_data, cyc + 1});
        wr_next = int'(ld_rd);
      end
      if (iss_valid && e_iss && iss_rd != 0) begin
        pend[iss_rd]++;
        owed.push_back(iss_rd);
      end
      if (wr_now != 0) pend[wr_now]--;
      wr_now = wr_next;
    end

    @(negedge clk);
    alu_valid = 1'b0;
    ld_valid  = 1'b0;
    iss_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
